// File: rtl/ov_chain_pkg.sv
// rtl/ov_chain_pkg.sv - shared types and defaults for the multi-word carry-chain adder
package ov_chain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WB    = 2'd2,
    DRAIN = 2'd3
  } ov_chain_state_t;

  localparam int WORD_W_DEF    = 8;
  localparam int MAX_WORDS_DEF = 4;

endpackage

// File: rtl/ov_word_alu.sv
// rtl/ov_word_alu.sv - one word of the add/subtract carry chain (combinational)
module ov_word_alu
  import ov_chain_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  input  logic              sub,
  output logic [WORD_W-1:0] s,
  output logic              cout,
  output logic              sovf
);

  logic [WORD_W-1:0] b_eff;
  logic [WORD_W:0]   total;

  // Subtraction is A + ~B + cin; signed overflow when both addends share a sign the result lacks
  always_comb begin
    b_eff = sub ? ~b : b;
    total = {1'b0, a} + {1'b0, b_eff} + {{WORD_W{1'b0}}, cin};
    s     = total[WORD_W-1:0];
    cout  = total[WORD_W];
    sovf  = (a[WORD_W-1] == b_eff[WORD_W-1]) && (s[WORD_W-1] != a[WORD_W-1]);
  end

endmodule

// File: rtl/ov_chain_adder.sv
// rtl/ov_chain_adder.sv - multi-word add/sub sequencer with overflow-register writeback (option: OV_CHAIN_SIGNED_EN)
module ov_chain_adder
  import ov_chain_pkg::*;
#(
  parameter  int WORD_W    = WORD_W_DEF,
  parameter  int MAX_WORDS = MAX_WORDS_DEF,
  localparam int CNT_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic              op_sub,
  input  logic              use_ov,
  input  logic [CNT_W-1:0]  num_words,
  input  logic              ov_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] a_word,
  input  logic [WORD_W-1:0] b_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] sum_word,
  output logic              ov_write,
  output logic              ov_data,
  output logic              busy,
  output logic              done
);

`ifdef OV_CHAIN_SIGNED_EN
  localparam bit SIGNED_OV = 1'b1;
`else
  localparam bit SIGNED_OV = 1'b0;
`endif

  ov_chain_state_t   state;
  ov_chain_state_t   state_next;
  logic [CNT_W-1:0]  words_left;
  logic              op_sub_q;
  logic              carry;
  logic              sovf_q;
  logic              launch;
  logic              accept;
  logic [WORD_W-1:0] alu_s;
  logic              alu_cout;
  logic              alu_sovf;

  ov_word_alu #(.WORD_W(WORD_W)) u_alu (
    .a    (a_word),
    .b    (b_word),
    .cin  (carry),
    .sub  (op_sub_q),
    .s    (alu_s),
    .cout (alu_cout),
    .sovf (alu_sovf)
  );

  assign launch = (state == IDLE) && start && (num_words != '0);
  assign accept = in_valid && in_ready;
  assign busy   = (state != IDLE);

  // Next-state and handshake/strobe outputs; everything defaults low
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    ov_write   = 1'b0;
    ov_data    = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (launch) state_next = RUN;
      end
      RUN: begin
        in_ready = (words_left != '0) && (!out_valid || out_ready);
        if (in_valid && in_ready && (words_left == CNT_W'(1))) state_next = WB;
      end
      WB: begin
        ov_write   = 1'b1;
        ov_data    = SIGNED_OV ? sovf_q : carry;
        state_next = DRAIN;
      end
      DRAIN: begin
        if (!out_valid || out_ready) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, operation latches, carry chain and the registered output word
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      words_left <= '0;
      op_sub_q   <= 1'b0;
      carry      <= 1'b0;
      sovf_q     <= 1'b0;
      out_valid  <= 1'b0;
      sum_word   <= '0;
    end else begin
      state <= state_next;
      if (launch) begin
        op_sub_q   <= op_sub;
        words_left <= num_words;
        carry      <= use_ov ? ov_in : op_sub;
      end
      if (accept) begin
        sum_word   <= alu_s;
        out_valid  <= 1'b1;
        carry      <= alu_cout;
        sovf_q     <= alu_sovf;
        words_left <= words_left - 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ov_chain_adder.sv
// tb/tb_ov_chain_adder.sv - randomized self-checking bench for ov_chain_adder (honours OV_CHAIN_SIGNED_EN)
module tb_ov_chain_adder;

  localparam int W  = 8;
  localparam int MW = 4;
  localparam int CW = $clog2(MW + 1);

  logic          CLK = 1'b0;
  logic          RESET;
  logic          start;
  logic          op_sub;
  logic          use_ov;
  logic [CW-1:0] num_words;
  logic          ov_in;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a_word;
  logic [W-1:0]  b_word;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum_word;
  logic          ov_write;
  logic          ov_data;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_bad = 0;

  ov_chain_adder dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .start     (start),
    .op_sub    (op_sub),
    .use_ov    (use_ov),
    .num_words (num_words),
    .ov_in     (ov_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_word    (a_word),
    .b_word    (b_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_word  (sum_word),
    .ov_write  (ov_write),
    .ov_data   (ov_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole operation modelled as one wide integer add; rmode: 0 ready high, 1 random, 2 low for cycles 2..4
  task automatic run_op(input bit sub, input bit uov, input bit ovi, input int n,
                        input logic [31:0] a_in, input logic [31:0] b_in, input int rmode);
    logic [39:0]  mask, a, bx, tot;
    logic [W-1:0] held;
    bit           exp_ov, cin, hold;
    int           sent, got, nwr, ndone, cyc;
    mask = (40'd1 << (n * W)) - 40'd1;
    a    = {8'h0, a_in} & mask;
    bx   = sub ? (~{8'h0, b_in}) & mask : {8'h0, b_in} & mask;
    cin  = uov ? ovi : sub;
    tot  = a + bx + {39'd0, cin};
    exp_ov = tot[n * W];
`ifdef OV_CHAIN_SIGNED_EN
    exp_ov = (a[n*W-1] == bx[n*W-1]) && (tot[n*W-1] != a[n*W-1]);
`endif
    @(negedge CLK);
    start = 1'b1; op_sub = sub; use_ov = uov; num_words = CW'(n); ov_in = ovi;
    @(negedge CLK);
    start = 1'b0;
    #1 check("busy_after_start", busy, 1);
    sent = 0; got = 0; nwr = 0; ndone = 0; cyc = 0; hold = 0; held = '0;
    while (ndone == 0 && cyc < 300) begin
      in_valid  = (rmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      a_word    = (sent < n) ? a_in[sent*W +: W] : W'($urandom);
      b_word    = (sent < n) ? b_in[sent*W +: W] : W'($urandom);
      out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ($urandom_range(0, 2) != 0)
                                                     : !(cyc >= 2 && cyc <= 4);
      ov_in     = 1'($urandom);
      start     = ($urandom_range(0, 5) == 0);
      num_words = CW'($urandom_range(0, MW));
      op_sub    = 1'($urandom);
      use_ov    = 1'($urandom);
      #1;
      if (hold) check("sum_hold", sum_word, held);
      if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
      if (in_valid && in_ready) begin
        if (sent >= n) check("extra_accept", 1, 0);
        else sent++;
      end
      if (out_valid && out_ready) begin
        if (got >= n) check("extra_output", 1, 0);
        else check($sformatf("sum_w%0d", got), sum_word, tot[got*W +: W]);
        got++;
      end
      if (ov_write) begin
        nwr++;
        check("ov_data", ov_data, exp_ov);
      end
      if (done) begin
        ndone++;
        check("words_out", got, n);
        check("ov_write_count", nwr, 1);
      end
      hold = out_valid && !out_ready;
      held = sum_word;
      @(negedge CLK);
      cyc++;
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("done_seen", ndone, 1);
    #1;
    check("idle_after_done", busy, 0);
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    RESET = 1'b1; start = 1'b0; op_sub = 1'b0; use_ov = 1'b0; num_words = '0; ov_in = 1'b0;
    in_valid = 1'b0; a_word = '0; b_word = '0; out_ready = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_ov_write", ov_write, 0);
    check("rst_ov_data", ov_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum_word", sum_word, 0);
    @(negedge CLK);
    RESET = 1'b0;

    run_op(1'b0, 1'b0, 1'b0, 2, 32'h0000_01FF, 32'h0000_0001, 0);
    run_op(1'b0, 1'b1, 1'b1, 1, 32'h0000_00FF, 32'h0000_0000, 0);
    run_op(1'b1, 1'b0, 1'b0, 2, 32'h0000_0100, 32'h0000_0001, 0);
    run_op(1'b0, 1'b0, 1'b0, 3, $urandom, $urandom, 2);
    run_op(1'b1, 1'b1, 1'b0, 4, $urandom, $urandom, 2);

    for (int i = 0; i < 40; i++)
      run_op(1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(1, MW),
             $urandom, $urandom, (i % 3 == 0) ? 0 : 1);

    // num_words == 0 start must be ignored
    @(negedge CLK);
    start = 1'b1; num_words = '0; op_sub = 1'b0; use_ov = 1'b0;
    @(negedge CLK);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("zero_busy", busy, 0);
      check("zero_ov_write", ov_write, 0);
      check("zero_done", done, 0);
      @(negedge CLK);
    end

    // reset mid-operation after one of three words
    start = 1'b1; num_words = CW'(3); op_sub = 1'b0; use_ov = 1'b0; out_ready = 1'b0;
    @(negedge CLK);
    start = 1'b0; in_valid = 1'b1; a_word = 8'h12; b_word = 8'h34;
    #1 check("rst_mid_accept", in_ready, 1);
    @(negedge CLK);
    in_valid = 1'b0;
    #1 check("rst_mid_pending", out_valid, 1);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_ov_write", ov_write, 0);
    check("rst_mid_done", done, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      #1;
      check("rst_after_ov_write", ov_write, 0);
      check("rst_after_done", done, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
